// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage Y86-64 core: per-cycle stall/bubble
// controls, CC write gating, RUN/HALTED freeze and saturating perf counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       prog_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_prog_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bub_cnt;

    logic w_lu;
    logic w_rt;
    logic w_mp;
    logic w_mx;
    logic w_wx;

    // Hazard terms: load/use, ret in flight, mispredicted jump, exceptions in M/W.
    assign w_lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                  (E_dstM != R_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign w_mp = (E_icode == I_JXX) && !e_Cnd;
    assign w_mx = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign w_wx = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (r_state == ST_HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end else begin
            F_stall  = w_lu | w_rt;
            D_stall  = w_lu;
            // A load/use stall holds the ret in D rather than bubbling over it.
            D_bubble = w_mp | (w_rt & !w_lu);
            E_bubble = w_mp | w_lu;
            M_bubble = w_mx | w_wx;
            W_stall  = w_wx;
            set_cc   = (E_icode == I_OPQ) & !w_mx & !w_wx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_RUN && w_wx) begin
            w_next_state = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_prog_stat <= S_AOK;
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_stall_cnt <= '0;
            r_bub_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN) begin
                if (w_wx) begin
                    r_prog_stat <= W_stat;
                end
                // Counters stick at all-ones instead of wrapping.
                if (r_cyc_cnt != '1) begin
                    r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
                end
                if ((W_icode != I_NOP) && (W_stat == S_AOK) && (r_ret_cnt != '1)) begin
                    r_ret_cnt <= r_ret_cnt + CNT_ONE;
                end
                if (D_stall && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_ONE;
                end
                if ((D_bubble || E_bubble) && (r_bub_cnt != '1)) begin
                    r_bub_cnt <= r_bub_cnt + CNT_ONE;
                end
            end
        end
    end

    assign halted    = (r_state == ST_HALTED);
    assign prog_stat = r_prog_stat;
    assign cyc_cnt   = r_cyc_cnt;
    assign ret_cnt   = r_ret_cnt;
    assign stall_cnt = r_stall_cnt;
    assign bub_cnt   = r_bub_cnt;

endmodule
